// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forwarding sequencer for a five-stage MIPS
// pipeline, plus the req/ready wait-state FSM for a variable-latency data
// memory with a timeout and a sticky error flag.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_count, flush_count
// and memwait_count performance counters.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_ra0,
  input  logic [4:0] d_ra1,
  input  logic [4:0] e_ra0,
  input  logic [4:0] e_ra1,
  input  logic [4:0] e_rf_wa,
  input  logic       e_rf_we,
  input  logic       e_is_load,
  input  logic [4:0] m_rf_wa,
  input  logic       m_rf_we,
  input  logic [4:0] w_rf_wa,
  input  logic       w_rf_we,
  input  logic       m_branch_taken,
  input  logic       m_mem_access,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       f_stall,
  output logic       d_stall,
  output logic       e_stall,
  output logic       m_stall,
  output logic       d_flush,
  output logic       e_flush,
  output logic       m_flush,
  output logic       w_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] memwait_count
`endif
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  // wait_cnt value at which the access is forced to complete
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_reg;
  logic [7:0] wait_cnt_reg;
  logic       mem_err_reg;

  logic       timeout_now;
  logic       mem_wait;
  logic       branch_flush;
  logic       load_use;
  logic [4:0] e_ra  [2];
  logic [1:0] fwd   [2];

  assign e_ra[0] = e_ra0;
  assign e_ra[1] = e_ra1;
  assign fwd_a   = reset ? 2'b00 : fwd[0];
  assign fwd_b   = reset ? 2'b00 : fwd[1];
  assign mem_err = mem_err_reg;

  // Operand forwarding; memory stage result is newer than writeback so it wins
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd[gi] = 2'b00;
        if (m_rf_we && (m_rf_wa != 5'd0) && (m_rf_wa == e_ra[gi]))
          fwd[gi] = 2'b10;
        else if (w_rf_we && (w_rf_wa != 5'd0) && (w_rf_wa == e_ra[gi]))
          fwd[gi] = 2'b01;
      end
    end
  endgenerate

  // Hazard detection and stall/flush arbitration: memory wait > branch > load-use
  always_comb begin
    timeout_now  = (state_reg == MEM_WAIT) && (wait_cnt_reg == TIMEOUT_LAST) && !dmem_ready;
    mem_wait     = m_mem_access && !dmem_ready && !timeout_now;
    branch_flush = m_branch_taken && !mem_wait;
    load_use     = e_is_load && e_rf_we && (e_rf_wa != 5'd0) &&
                   ((e_rf_wa == d_ra0) || (e_rf_wa == d_ra1)) &&
                   !mem_wait && !m_branch_taken;

    dmem_req = 1'b0;
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    e_stall  = 1'b0;
    m_stall  = 1'b0;
    d_flush  = 1'b0;
    e_flush  = 1'b0;
    m_flush  = 1'b0;
    w_flush  = 1'b0;

    if (reset) begin
      // Hold every stage register as a bubble while reset is applied
      d_flush = 1'b1;
      e_flush = 1'b1;
      m_flush = 1'b1;
      w_flush = 1'b1;
    end else begin
      dmem_req = m_mem_access;
      if (mem_wait) begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        e_stall = 1'b1;
        m_stall = 1'b1;
        w_flush = 1'b1;
      end else if (branch_flush) begin
        d_flush = 1'b1;
        e_flush = 1'b1;
        m_flush = 1'b1;
      end else if (load_use) begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        e_flush = 1'b1;
      end
    end
  end

  // Memory wait-state FSM, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 8'd0;
      mem_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          wait_cnt_reg <= 8'd0;
          if (m_mem_access && !dmem_ready)
            state_reg <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (dmem_ready || timeout_now) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
            if (timeout_now)
              mem_err_reg <= 1'b1;
          end else if (wait_cnt_reg != 8'hFF) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running performance counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count   <= 32'd0;
      flush_count   <= 32'd0;
      memwait_count <= 32'd0;
    end else begin
      if (f_stall)
        stall_count <= stall_count + 32'd1;
      if (branch_flush)
        flush_count <= flush_count + 32'd1;
      if (state_reg == MEM_WAIT)
        memwait_count <= memwait_count + 32'd1;
    end
  end
`endif

endmodule
